// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
//   mem_state_t  : handshake FSM states (IDLE, WAIT, DONE, HOLD)
//   DATA_W       : memory word width
//   RD_OOR_VALUE : data returned by a read whose address is beyond the array
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] RD_OOR_VALUE = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    HOLD
  } mem_state_t;

endpackage

// File: rtl/mem_array_sp.sv
// Synchronous single-port word array with a registered read port.
// Ports:
//   clk_i    : clock, rising edge
//   clear_i  : synchronous active-high reset of the read register only
//   we_i     : write enable (one word per asserted edge)
//   re_i     : read enable; rdata_o updates only on an enabled edge
//   addr_i   : word address; addresses >= DEPTH drop writes and read RD_OOR_VALUE
//   wdata_i  : write data
//   rdata_o  : registered read data, held between reads
module mem_array_sp
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IdxW-1:0]   idx;
  logic              in_range;

  // Range test is done on the full address so no wrap into the array occurs.
  assign in_range = (32'(addr_i) < DEPTH);
  assign idx      = addr_i[IdxW-1:0];

  // Array contents survive clear.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= in_range ? mem_q[idx] : RD_OOR_VALUE;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: answers datapath Read/Write requests with configurable wait-state latency.
// A request is accepted on an IDLE edge with Read|Write high (Write wins), completes
// LATENCY edges later (array write or Mdata_out update), pulses mem_ready for one cycle,
// then waits in HOLD until both request lines drop so a held request never repeats.
// Ports:
//   clock     : clock, rising edge
//   clear     : synchronous active-high reset (array contents kept)
//   Read      : read request level
//   Write     : write request level
//   address   : word address, latched at accept
//   data_in   : write data, latched at accept
//   Mdata_out : read data, held until the next read completes
//   mem_ready : one-cycle completion strobe
//   busy      : high from accept until return to IDLE
//   mem_err   : only when MEM_ERR_EN is defined; high with mem_ready for an
//               out-of-range latched address
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Mdata_out,
  output logic              mem_ready,
  output logic              busy
`ifdef MEM_ERR_EN
  ,
  output logic              mem_err
`endif
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              mem_ready_q;
  logic              busy_q;
  logic              complete;

  // The completion edge is N+LATENCY: WAIT is entered at N and counts LATENCY edges,
  // so LATENCY=1 spends exactly one cycle in WAIT before DONE.
  assign complete = (state_q == WAIT) && (cnt_q == CntW'(LATENCY - 1)) && !clear;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_ready_q <= 1'b0;
          if (Read || Write) begin
            op_wr_q <= Write;
            addr_q  <= address;
            data_q  <= data_in;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (complete) begin
            mem_ready_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          mem_ready_q <= 1'b0;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (!Read && !Write) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  mem_array_sp #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .clear_i (clear),
    .we_i    (complete && op_wr_q),
    .re_i    (complete && !op_wr_q),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (Mdata_out)
  );

`ifdef MEM_ERR_EN
  logic mem_err_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      mem_err_q <= 1'b0;
    end else begin
      // High only during DONE, i.e. alongside mem_ready.
      mem_err_q <= complete && (32'(addr_q) >= DEPTH);
    end
  end

  assign mem_err = mem_err_q;
`endif

  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;

endmodule
